// File: rtl/spi_pkg.sv
// Shared types and widths for the SPI peripheral receive path.
package spi_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned INDEX_W = 16;

    typedef logic [BYTE_W-1:0] spi_byte_t;

    typedef enum logic [1:0] {
        IDLE,
        OPCODE,
        DATA
    } spi_state_e;

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-stage synchronizer with registered rise/fall event detection.
module spi_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   lvl;

    assign lvl = sync_q[SYNC_STAGES-1];

    // Chain resets low: a pin already low at reset release produces no fall event.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= lvl;
            rise_q <= lvl & ~prev_q;
            fall_q <= ~lvl & prev_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/spi_peripheral_rx.sv
// SPI mode-0 target: opcode/write-data byte strobes plus response shift-out.
// Optional TX path enabled by defining SPI_PERIPHERAL_RX_CIPO_EN.
module spi_peripheral_rx
    import spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               sck,
    input  logic               cs,
    input  logic               copi,
    output logic               cipo,
    output logic [BYTE_W-1:0]  opcode,
    output logic               opcode_valid,
    output logic [BYTE_W-1:0]  wr_data,
    output logic               wr_valid,
    output logic [INDEX_W-1:0] byte_index,
    output logic               rd_req,
    input  logic [BYTE_W-1:0]  rd_data,
    output logic               busy,
    output logic               txn_end
);

    logic sck_rise, sck_fall, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] copi_sync_q;
    logic copi_s;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
        .clk(clk), .reset_n(reset_n), .d_i(sck), .rise_o(sck_rise), .fall_o(sck_fall)
    );

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clk(clk), .reset_n(reset_n), .d_i(cs), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) copi_sync_q <= '0;
        else          copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
    end
    assign copi_s = copi_sync_q[SYNC_STAGES-1];

    spi_state_e         state_q, state_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    spi_byte_t          shift_q, shift_d;
    spi_byte_t          opcode_q, opcode_d;
    spi_byte_t          wr_data_q, wr_data_d;
    logic [INDEX_W-1:0] idx_q, idx_d;
    logic               opv_q, opv_d, wrv_q, wrv_d;
    logic               end_q, end_d, end_pend_q, end_pend_d;
    logic               active, byte_done;
    spi_byte_t          rx_byte;

    assign active    = (state_q != IDLE);
    assign byte_done = active && sck_rise && (bit_cnt_q == 3'd7);
    assign rx_byte   = {shift_q[BYTE_W-2:0], copi_s};

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        opcode_d   = opcode_q;
        wr_data_d  = wr_data_q;
        idx_d      = idx_q;
        opv_d      = 1'b0;
        wrv_d      = 1'b0;
        end_d      = end_pend_q;
        end_pend_d = 1'b0;

        if (wrv_q && (idx_q != '1)) idx_d = idx_q + 16'd1;

        if (!active) begin
            if (cs_fall) begin
                state_d   = OPCODE;
                bit_cnt_d = '0;
                shift_d   = '0;
            end
        end else begin
            if (sck_rise) begin
                shift_d   = rx_byte;
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
            if (byte_done) begin
                if (state_q == OPCODE) begin
                    opcode_d = rx_byte;
                    opv_d    = 1'b1;
                    idx_d    = '0;
                    state_d  = DATA;
                end else begin
                    wr_data_d = rx_byte;
                    wrv_d     = 1'b1;
                end
            end
            // A byte finishing with cs rising still strobes; txn_end is pushed a cycle later.
            if (cs_rise) begin
                state_d   = IDLE;
                bit_cnt_d = '0;
                shift_d   = '0;
                if (byte_done) begin
                    end_pend_d = 1'b1;
                    end_d      = 1'b0;
                end else begin
                    end_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            opcode_q   <= '0;
            wr_data_q  <= '0;
            idx_q      <= '0;
            opv_q      <= 1'b0;
            wrv_q      <= 1'b0;
            end_q      <= 1'b0;
            end_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            opcode_q   <= opcode_d;
            wr_data_q  <= wr_data_d;
            idx_q      <= idx_d;
            opv_q      <= opv_d;
            wrv_q      <= wrv_d;
            end_q      <= end_d;
            end_pend_q <= end_pend_d;
        end
    end

`ifdef SPI_PERIPHERAL_RX_CIPO_EN
    spi_byte_t tx_q, tx_d;
    logic      load_pend_q, load_pend_d, rdreq_q, tx_clear;

    assign tx_clear = active ? cs_rise : cs_fall;

    // rd_data is captured on the first falling edge after a request, then shifted.
    always_comb begin
        tx_d        = tx_q;
        load_pend_d = load_pend_q;
        if (tx_clear) begin
            tx_d        = '0;
            load_pend_d = 1'b0;
        end else if (active) begin
            if (byte_done) load_pend_d = 1'b1;
            if (sck_fall) begin
                if (load_pend_q) begin
                    tx_d        = rd_data;
                    load_pend_d = 1'b0;
                end else begin
                    tx_d = {tx_q[BYTE_W-2:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_q        <= '0;
            load_pend_q <= 1'b0;
            rdreq_q     <= 1'b0;
        end else begin
            tx_q        <= tx_d;
            load_pend_q <= load_pend_d;
            rdreq_q     <= byte_done;
        end
    end

    assign cipo   = active & tx_q[BYTE_W-1];
    assign rd_req = rdreq_q;
`else
    logic unused_rd_data;
    assign unused_rd_data = ^rd_data;
    assign cipo   = 1'b0;
    assign rd_req = 1'b0;
`endif

    assign opcode       = opcode_q;
    assign opcode_valid = opv_q;
    assign wr_data      = wr_data_q;
    assign wr_valid     = wrv_q;
    assign byte_index   = idx_q;
    assign busy         = active;
    assign txn_end      = end_q;

endmodule
